// File: rtl/semaphore_controller.sv
// semaphore_controller: round-robin sequencer for a bank of semaphore units.
// Enables one unit at a time, times its four light phases with a clock
// prescaler and a per-phase dwell counter, broadcasts a one-cycle `next` at
// the end of each phase and checks the unit's `done` handshake on wrap.
module semaphore_controller #(
    parameter int N_UNITS      = 4,
    parameter int CLK_PER_TICK = 1000,
    parameter int RED_TICKS    = 2,
    parameter int YELLOW_TICKS = 3,
    parameter int GREEN_TICKS  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [N_UNITS-1:0]         done,
    output logic [N_UNITS-1:0]         en,
    output logic                       next,
    output logic [$clog2(N_UNITS)-1:0] active_idx,
    output logic [1:0]                 phase,
    output logic                       busy,
    output logic                       err
);

    localparam int IW = $clog2(N_UNITS);

    localparam logic [15:0] CPT_MAX    = 16'(CLK_PER_TICK - 1);
    localparam logic [15:0] RED_MAX    = 16'(RED_TICKS - 1);
    localparam logic [15:0] YELLOW_MAX = 16'(YELLOW_TICKS - 1);
    localparam logic [15:0] GREEN_MAX  = 16'(GREEN_TICKS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_UNITS - 1);
    localparam logic [N_UNITS-1:0] ONE = N_UNITS'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [15:0]   presc, presc_n;
    logic [15:0]   dwell, dwell_n;
    logic [1:0]    phase_n;
    logic [IW-1:0] idx_n;
    logic          err_n;
    logic          next_n;
    logic [N_UNITS-1:0] en_n;
    logic [N_UNITS-1:0] sel;
    logic          unit_end;
    logic          proto_err;

    // Last dwell count (ticks - 1) of a given phase.
    function automatic logic [15:0] dwell_max(input logic [1:0] p);
        case (p)
            2'd0:    dwell_max = RED_MAX;
            2'd2:    dwell_max = GREEN_MAX;
            default: dwell_max = YELLOW_MAX;
        endcase
    endfunction

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_n   = state;
        presc_n   = presc;
        dwell_n   = dwell;
        phase_n   = phase;
        idx_n     = active_idx;
        err_n     = err;
        sel       = ONE << active_idx;
        unit_end  = next && (phase == 2'd3);
        proto_err = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_n = ACTIVE;
                    phase_n = 2'd0;
                    presc_n = '0;
                    dwell_n = '0;
                end
            end
            ACTIVE: begin
                proto_err = (unit_end && !done[active_idx])
                          || (|(done & ~sel))
                          || (!unit_end && (|done));
                if (proto_err) begin
                    state_n = ERROR;
                    err_n   = 1'b1;
                end else if (next) begin
                    presc_n = '0;
                    dwell_n = '0;
                    phase_n = phase + 2'd1;
                    if (unit_end) begin
                        idx_n = (active_idx == LAST_IDX) ? '0 : active_idx + 1'b1;
                        if (!run) begin
                            state_n = IDLE;
                        end
                    end
                end else if (presc == CPT_MAX) begin
                    presc_n = '0;
                    dwell_n = dwell + 16'd1;
                end else begin
                    presc_n = presc + 16'd1;
                end
            end
            default: begin
                state_n = ERROR;
                err_n   = 1'b1;
            end
        endcase

        // next/en are registered: decode them from the upcoming counter state
        // so they line up with the cycle in which the tick actually occurs.
        next_n = (state_n == ACTIVE) && (presc_n == CPT_MAX)
              && (dwell_n == dwell_max(phase_n));
        en_n   = (state_n == ACTIVE) ? (ONE << idx_n) : '0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            presc      <= '0;
            dwell      <= '0;
            phase      <= '0;
            active_idx <= '0;
            err        <= 1'b0;
            next       <= 1'b0;
            en         <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            dwell      <= dwell_n;
            phase      <= phase_n;
            active_idx <= idx_n;
            err        <= err_n;
            next       <= next_n;
            en         <= en_n;
            busy       <= (state_n == ACTIVE);
        end
    end

endmodule

// File: tb/tb_semaphore_controller.sv
// Directed bench for semaphore_controller with a behavioural unit model
// (per-unit phase tracker producing `done`) plus fault-injection knobs.
module tb_semaphore_controller;

    logic       clk;
    logic       reset;
    logic       run;
    logic [2:0] done;
    logic [2:0] en;
    logic       next;
    logic [1:0] active_idx;
    logic [1:0] phase;
    logic       busy;
    logic       err;

    logic       stub0;
    logic [2:0] force_done;
    logic [1:0] uphase [3];

    int checks = 0;
    int errors = 0;

    semaphore_controller #(
        .N_UNITS      (3),
        .CLK_PER_TICK (2),
        .RED_TICKS    (1),
        .YELLOW_TICKS (2),
        .GREEN_TICKS  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .done       (done),
        .en         (en),
        .next       (next),
        .active_idx (active_idx),
        .phase      (phase),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit model: each unit tracks its own phase and pulses done on its wrap.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 3; i++) uphase[i] <= 2'd0;
        end else begin
            for (int unsigned i = 0; i < 3; i++)
                if (en[i] && next) uphase[i] <= uphase[i] + 2'd1;
        end
    end

    always_comb begin
        done = force_done;
        for (int unsigned i = 0; i < 3; i++)
            if (en[i] && next && uphase[i] == 2'd3 && !(i == 0 && stub0))
                done[i] = 1'b1;
    end

    // Reset, release with run high; returns sampling in cycle c0.
    task automatic start_c0();
        reset = 1'b0;
        run   = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        run   = 1'b1;
        #1;
        checks++;
        if ({en, next, active_idx, phase, busy, err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {en, next, active_idx, phase, busy, err}, 10'd0);
        end
        step(2);
        checks++;
        if ({en, busy, err} !== 5'd0) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", {en, busy, err}, 5'd0);
        end
    endtask

    task automatic test_single_unit();
        logic       exp_next;
        logic [1:0] exp_ph;
        logic [2:0] exp_en;
        start_c0();
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL c0_busy_err: got %b expected %b", {busy, err}, 2'b10);
        end
        for (int unsigned c = 0; c <= 16; c++) begin
            exp_next = (c == 1 || c == 5 || c == 11 || c == 15);
            exp_ph   = (c < 2) ? 2'd0 : (c < 6) ? 2'd1 : (c < 12) ? 2'd2 : (c < 16) ? 2'd3 : 2'd0;
            exp_en   = (c < 16) ? 3'b001 : 3'b010;
            checks++;
            if ({en, next, phase} !== {exp_en, exp_next, exp_ph}) begin
                errors++;
                $display("FAIL unit0_c%0d en/next/phase: got %b/%b/%0d expected %b/%b/%0d",
                         c, en, next, phase, exp_en, exp_next, exp_ph);
            end
            if (c == 15) begin
                checks++;
                if (done !== 3'b001) begin
                    errors++;
                    $display("FAIL unit0_done: got %b expected %b", done, 3'b001);
                end
            end
            if (c != 16) step(1);
        end
        checks++;
        if ({active_idx, err} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL handover: got idx %0d err %b expected idx 1 err 0", active_idx, err);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx;
        logic [2:0] exp_en;
        start_c0();
        for (int unsigned k = 0; k < 4; k++) begin
            exp_idx = 2'(k % 3);
            exp_en  = 3'b001 << exp_idx;
            checks++;
            if ({active_idx, en, err, busy} !== {exp_idx, exp_en, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL rr_%0d idx/en/err/busy: got %0d/%b/%b/%b expected %0d/%b/0/1",
                         k, active_idx, en, err, busy, exp_idx, exp_en);
            end
            if (k != 3) step(16);
        end
    endtask

    task automatic test_stop_boundary();
        start_c0();
        step(7);
        run = 1'b0;
        step(8);
        checks++;
        if ({busy, en, next, phase} !== {1'b1, 3'b001, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL stop_c15: got busy %b en %b next %b phase %0d expected 1 001 1 3",
                     busy, en, next, phase);
        end
        step(1);
        checks++;
        if ({busy, en, next, active_idx, phase, err} !== {1'b0, 3'b000, 1'b0, 2'd1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL stop_idle: got busy %b en %b next %b idx %0d phase %0d err %b expected 0 000 0 1 0 0",
                     busy, en, next, active_idx, phase, err);
        end
        step(3);
        checks++;
        if ({busy, en} !== 4'b0000) begin
            errors++;
            $display("FAIL stop_stays_idle: got busy %b en %b expected 0 000", busy, en);
        end
        run = 1'b1;
        step(1);
        checks++;
        if ({busy, en, active_idx, phase, next} !== {1'b1, 3'b010, 2'd1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_unit1: got busy %b en %b idx %0d phase %0d next %b expected 1 010 1 0 0",
                     busy, en, active_idx, phase, next);
        end
        step(1);
        checks++;
        if (next !== 1'b1) begin
            errors++;
            $display("FAIL restart_first_next: got %b expected 1", next);
        end
    endtask

    task automatic test_missing_done();
        stub0 = 1'b1;
        start_c0();
        step(15);
        checks++;
        if ({next, phase, err} !== {1'b1, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL missing_c15: got next %b phase %0d err %b expected 1 3 0", next, phase, err);
        end
        step(1);
        checks++;
        if ({err, en, busy, next} !== {1'b1, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL missing_err: got err %b en %b busy %b next %b expected 1 000 0 0",
                     err, en, busy, next);
        end
        step(20);
        checks++;
        if ({err, en, busy, next} !== {1'b1, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL missing_sticky: got err %b en %b busy %b next %b expected 1 000 0 0",
                     err, en, busy, next);
        end
        stub0 = 1'b0;
    endtask

    task automatic test_spurious_done();
        start_c0();
        step(4);
        force_done = 3'b100;
        #1;
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL spurious_c4: got err %b busy %b expected 0 1", err, busy);
        end
        step(1);
        force_done = 3'b000;
        checks++;
        if ({err, en, busy, next} !== {1'b1, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL spurious_err: got err %b en %b busy %b next %b expected 1 000 0 0",
                     err, en, busy, next);
        end
    endtask

    task automatic test_async_reset();
        start_c0();
        step(8);
        checks++;
        if ({phase, busy} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL green_c8: got phase %0d busy %b expected 2 1", phase, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({en, next, active_idx, phase, busy, err} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b",
                     {en, next, active_idx, phase, busy, err}, 10'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({en, active_idx, phase, busy, next} !== {3'b001, 2'd0, 2'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL restart_after_reset: got en %b idx %0d phase %0d busy %b next %b expected 001 0 0 1 0",
                     en, active_idx, phase, busy, next);
        end
        step(1);
        checks++;
        if (next !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_reset_next: got %b expected 1", next);
        end
    endtask

    initial begin
        reset      = 1'b0;
        run        = 1'b0;
        stub0      = 1'b0;
        force_done = 3'b000;
        test_reset();
        test_single_unit();
        test_round_robin();
        test_stop_boundary();
        test_missing_done();
        test_spurious_done();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
